sqrt_job_scheduler: RTL and testbench

SQRT_JOB_SCHEDULER -- requirements
Module: sqrt_job_scheduler

---
 rtl/sqrt_job_scheduler_pkg.sv | 43 ++++
 rtl/sqrt_job_scheduler_if.sv | 33 +++
 rtl/sqrt_job_scheduler_sync_fifo.sv | 73 +++++++
 rtl/sqrt_job_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_sqrt_job_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_job_scheduler_pkg.sv
// sqrt_sched_pkg: shared definitions for the square-root job scheduler.
// Holds the FSM state encoding, register word offsets (addr[3:2]), CTRL bit
// indices, STATUS bit positions and a small count-saturation helper.
package sqrt_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    // Register word offsets, compared against addr[3:2]
    localparam logic [1:0] REG_OP_PUSH     = 2'd0;
    localparam logic [1:0] REG_RESULT      = 2'd1;
    localparam logic [1:0] REG_STATUS_CTRL = 2'd2;
    localparam logic [1:0] REG_IRQ_EN      = 2'd3;

    // CTRL write bits; every set bit acts in the same cycle
    localparam int CTRL_POP_BIT     = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;
    localparam int CTRL_FLUSH_BIT   = 2;

    // STATUS read bit positions
    localparam int STAT_OP_EMPTY      = 0;
    localparam int STAT_OP_FULL       = 1;
    localparam int STAT_RES_EMPTY     = 2;
    localparam int STAT_RES_FULL      = 3;
    localparam int STAT_BUSY          = 4;
    localparam int STAT_OVF_ERR       = 5;
    localparam int STAT_OP_COUNT_LSB  = 8;
    localparam int STAT_RES_COUNT_LSB = 12;

    // The STATUS count fields are 4 bits wide; a depth-16 FIFO holding 16
    // entries reports 15 there (the full flag disambiguates).
    function automatic logic [3:0] sat_count4(input logic [4:0] cnt);
        if (cnt > 5'd15) begin
            return 4'hF;
        end else begin
            return cnt[3:0];
        end
    endfunction

endpackage

// File: rtl/sqrt_job_scheduler_if.sv
// sqrt_job_scheduler_if: bus and sqrt-core signals of the job scheduler.
//   cs, we, addr, wdata   register write/select from the host bus
//   rdata                 combinational register read data
//   core_start            one-cycle start pulse to the sqrt core
//   core_operand          operand, stable from start until done
//   core_done             one-cycle completion pulse from the core
//   core_result           result, valid while core_done is high
//   irq                   level interrupt, result available
// slave = scheduler view, master = host/core view.
interface sqrt_job_scheduler_if #(
    parameter int RES_W = 16
);
    logic             cs;
    logic             we;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             core_start;
    logic [31:0]      core_operand;
    logic             core_done;
    logic [RES_W-1:0] core_result;
    logic             irq;

    modport slave (
        input  cs, we, addr, wdata, core_done, core_result,
        output rdata, core_start, core_operand, irq
    );

    modport master (
        output cs, we, addr, wdata, core_done, core_result,
        input  rdata, core_start, core_operand, irq
    );
endinterface

// File: rtl/sqrt_job_scheduler_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous active-low reset and flush.
//   clk, reset_n   clock and synchronous active-low reset
//   flush          empties the FIFO; wins over push and pop
//   push, wdata    write request (ignored when full)
//   pop            read request (ignored when empty)
//   rdata          head entry (meaningful only when not empty)
//   full, empty    state of the current cycle
//   count          number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against the current full/empty flags
    always_comb begin
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
    end

    // Storage array; no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));
    assign count = count_r;

endmodule

// File: rtl/sqrt_job_scheduler.sv
// sqrt_job_scheduler: queues operands for an external sqrt core, issues them
// one at a time and buffers the returned results for the host.
//   clk       sole clock, rising edge
//   reset_n   synchronous active-low reset
//   bus       sqrt_job_scheduler_if.slave: cs/we/addr/wdata/rdata register
//             port (0x0 OP_PUSH, 0x4 RESULT, 0x8 STATUS/CTRL, 0xC IRQ_EN),
//             core_start/core_operand/core_done/core_result core port, irq
// Parameters: FIFO_DEPTH (operand and result FIFO depth), RES_W (result width).
// Optional macro SQRT_SCHED_IRQ_EN enables the IRQ_EN register and irq output;
// without it irq is tied low and 0xC reads as zero.
module sqrt_job_scheduler
    import sqrt_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RES_W      = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    sqrt_job_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e           state_r;
    state_e           next_state_s;
    logic             op_full_s, op_empty_s, res_full_s, res_empty_s;
    logic [CNT_W-1:0] op_count_s, res_count_s;
    logic [31:0]      op_head_s;
    logic [RES_W-1:0] res_head_s;
    logic [1:0]       reg_sel_s;
    logic             wr_s, push_req_s, ctrl_wr_s;
    logic             flush_s, res_pop_s, clr_ovf_s;
    logic             op_pop_s, res_push_s;
    logic             ovf_err_r, discard_r, core_start_r;
    logic [31:0]      core_operand_r;
    logic [31:0]      status_s, rdata_s;
    logic             irq_en_s;
    logic             unused_addr_s;

    assign reg_sel_s     = bus.addr[3:2];
    assign unused_addr_s = ^{bus.addr[31:4], bus.addr[1:0]};

    // Register write decode and CTRL actions
    always_comb begin
        wr_s       = bus.cs & bus.we;
        push_req_s = wr_s & (reg_sel_s == REG_OP_PUSH);
        ctrl_wr_s  = wr_s & (reg_sel_s == REG_STATUS_CTRL);
        flush_s    = ctrl_wr_s & bus.wdata[CTRL_FLUSH_BIT];
        clr_ovf_s  = ctrl_wr_s & bus.wdata[CTRL_CLR_OVF_BIT];
        res_pop_s  = ctrl_wr_s & bus.wdata[CTRL_POP_BIT] & ~res_empty_s;
    end

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_op_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush_s),
        .push    (push_req_s),
        .pop     (op_pop_s),
        .wdata   (bus.wdata),
        .rdata   (op_head_s),
        .full    (op_full_s),
        .empty   (op_empty_s),
        .count   (op_count_s)
    );

    sync_fifo #(.WIDTH(RES_W), .DEPTH(FIFO_DEPTH)) u_res_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush_s),
        .push    (res_push_s),
        .pop     (res_pop_s),
        .wdata   (bus.core_result),
        .rdata   (res_head_s),
        .full    (res_full_s),
        .empty   (res_empty_s),
        .count   (res_count_s)
    );

    // Sticky overflow flag: a push against a full operand FIFO is dropped
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_err_r <= 1'b0;
        end else if (clr_ovf_s) begin
            ovf_err_r <= 1'b0;
        end else if (push_req_s && op_full_s) begin
            ovf_err_r <= 1'b1;
        end else begin
            ovf_err_r <= ovf_err_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state; issue only when a result slot is guaranteed
    always_comb begin
        next_state_s = state_r;
        op_pop_s     = 1'b0;
        res_push_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                // A flush in this cycle empties the queue, so do not launch
                if (!op_empty_s && !res_full_s && !flush_s) begin
                    next_state_s = S_ISSUE;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                op_pop_s     = 1'b1;
                next_state_s = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    next_state_s = S_IDLE;
                    if (!flush_s && !discard_r) begin
                        res_push_s = 1'b1;
                    end else begin
                        res_push_s = 1'b0;
                    end
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Remembers that the job in flight was flushed so its result is dropped
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            discard_r <= 1'b0;
        end else if (state_r == S_WAIT && bus.core_done) begin
            discard_r <= 1'b0;
        end else if (flush_s && state_r != S_IDLE) begin
            discard_r <= 1'b1;
        end else begin
            discard_r <= discard_r;
        end
    end

    // Core start pulse and operand, registered so they align with ISSUE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            core_start_r   <= 1'b0;
            core_operand_r <= 32'd0;
        end else if (next_state_s == S_ISSUE) begin
            core_start_r   <= 1'b1;
            core_operand_r <= op_head_s;
        end else begin
            core_start_r   <= 1'b0;
            core_operand_r <= core_operand_r;
        end
    end

`ifdef SQRT_SCHED_IRQ_EN
    logic irq_en_r;

    // Interrupt enable register at offset 0xC
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_en_r <= 1'b0;
        end else if (wr_s && reg_sel_s == REG_IRQ_EN) begin
            irq_en_r <= bus.wdata[0];
        end else begin
            irq_en_r <= irq_en_r;
        end
    end

    assign irq_en_s = irq_en_r;
`else
    assign irq_en_s = 1'b0;
`endif

    // STATUS word assembly
    always_comb begin
        status_s                                  = 32'd0;
        status_s[STAT_OP_EMPTY]                   = op_empty_s;
        status_s[STAT_OP_FULL]                    = op_full_s;
        status_s[STAT_RES_EMPTY]                  = res_empty_s;
        status_s[STAT_RES_FULL]                   = res_full_s;
        status_s[STAT_BUSY]                       = (state_r != S_IDLE);
        status_s[STAT_OVF_ERR]                    = ovf_err_r;
        status_s[STAT_OP_COUNT_LSB +: 4]          = sat_count4(5'(op_count_s));
        status_s[STAT_RES_COUNT_LSB +: 4]         = sat_count4(5'(res_count_s));
    end

    // Side-effect-free read mux
    always_comb begin
        rdata_s = 32'd0;
        if (bus.cs) begin
            case (reg_sel_s)
                REG_RESULT: begin
                    if (res_empty_s) begin
                        rdata_s = 32'd0;
                    end else begin
                        rdata_s = 32'(res_head_s);
                    end
                end
                REG_STATUS_CTRL: rdata_s = status_s;
                REG_IRQ_EN:      rdata_s = {31'd0, irq_en_s};
                default:         rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.rdata        = rdata_s;
    assign bus.core_start   = core_start_r;
    assign bus.core_operand = core_operand_r;
    assign bus.irq          = irq_en_s & ~res_empty_s;

endmodule

// File: tb/tb_sqrt_job_scheduler.sv
`timescale 1ns/1ps
module tb_sqrt_job_scheduler;
    localparam int RES_W = 16;
    localparam logic [31:0] A_PUSH   = 32'h600;
    localparam logic [31:0] A_RESULT = 32'h604;
    localparam logic [31:0] A_STATUS = 32'h608;
    localparam logic [31:0] A_IRQEN  = 32'h60C;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sqrt_job_scheduler_if #(.RES_W(RES_W)) bus ();

    sqrt_job_scheduler #(.FIFO_DEPTH(4), .RES_W(RES_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    // Behavioural sqrt core: floor(sqrt(op)) after core_latency cycles
    int               core_latency = 17;
    logic             core_stall = 1'b0;
    logic             core_active = 1'b0;
    int               core_cnt = 0;
    int               core_starts = 0;
    logic [31:0]      core_op = 32'd0;
    logic             core_done_m = 1'b0;
    logic [RES_W-1:0] core_result_m = '0;

    assign bus.core_done   = core_done_m;
    assign bus.core_result = core_result_m;

    function automatic logic [31:0] isqrt_ref(input logic [31:0] v);
        longint unsigned lo, hi, mid, vv;
        vv = {32'd0, v};
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= vv) lo = mid;
            else hi = mid - 1;
        end
        return 32'(lo);
    endfunction

    always @(negedge clk) begin
        core_done_m = 1'b0;
        if (core_active && !core_stall) begin
            if (core_cnt == 0) begin
                core_done_m   = 1'b1;
                core_result_m = RES_W'(isqrt_ref(core_op));
                core_active   = 1'b0;
            end else begin
                core_cnt = core_cnt - 1;
            end
        end
        if (bus.core_start === 1'b1) begin
            core_active = 1'b1;
            core_cnt    = core_latency - 1;
            core_op     = bus.core_operand;
            core_starts = core_starts + 1;
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
        #1;
        d = bus.rdata;
        bus.cs = 1'b0;
    endtask

    // Polls STATUS until k results are buffered and the scheduler is idle
    task automatic wait_results(input int k, input int budget, output bit ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bus_read(A_STATUS, s);
            if (s[15:12] == 4'(k) && s[4] == 1'b0 && s[0] == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++; if (bus.core_start !== 1'b0) begin n_fail++; $display("FAIL reset_core_start: got %b expected 0", bus.core_start); end
        n_cmp++; if (bus.core_operand !== 32'd0) begin n_fail++; $display("FAIL reset_core_operand: got %h expected 0", bus.core_operand); end
        n_cmp++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h5) begin n_fail++; $display("FAIL reset_status: got %h expected %h", d, 32'h5); end
        bus_read(A_RESULT, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", d); end
        bus_read(A_IRQEN, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_irq_en: got %h expected 0", d); end
    endtask

    task automatic test_single_job();
        logic [31:0] d;
        bit ok;
        core_latency = 17;
        bus_write(A_PUSH, 32'h100);
        @(posedge clk); #1;
        n_cmp++; if (bus.core_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", bus.core_start); end
        n_cmp++; if (bus.core_operand !== 32'h100) begin n_fail++; $display("FAIL single_operand: got %h expected %h", bus.core_operand, 32'h100); end
        wait_results(1, 60, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got no result expected 1 result"); end
        bus_read(A_RESULT, d);
        n_cmp++; if (d !== 32'h10) begin n_fail++; $display("FAIL single_result: got %h expected %h", d, 32'h10); end
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h1001) begin n_fail++; $display("FAIL single_status: got %h expected %h", d, 32'h1001); end
        bus_write(A_STATUS, 32'h1);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h5) begin n_fail++; $display("FAIL single_pop_status: got %h expected %h", d, 32'h5); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] ops[4];
        bit ok;
        int s0;
        ops[0] = 32'd16; ops[1] = 32'd81; ops[2] = 32'd144; ops[3] = 32'hFFFF_FFFF;
        exp_q.push_back(32'd4); exp_q.push_back(32'd9);
        exp_q.push_back(32'd12); exp_q.push_back(32'hFFFF);
        core_latency = int'($urandom_range(2, 8));
        s0 = core_starts;
        for (int i = 0; i < 4; i++) bus_write(A_PUSH, ops[i]);
        wait_results(4, 200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got incomplete expected 4 results"); end
        n_cmp++; if (core_starts - s0 !== 4) begin n_fail++; $display("FAIL b2b_starts: got %0d expected 4", core_starts - s0); end
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h4009) begin n_fail++; $display("FAIL b2b_status: got %h expected %h", d, 32'h4009); end
        bus_read(A_RESULT, d);
        n_cmp++; if (d !== exp_q[0]) begin n_fail++; $display("FAIL b2b_head: got %h expected %h", d, exp_q[0]); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        bus_write(A_PUSH, 32'd25); bus_write(A_PUSH, 32'd36);
        bus_write(A_PUSH, 32'd49); bus_write(A_PUSH, 32'd64);
        exp_q.push_back(32'd5); exp_q.push_back(32'd6);
        exp_q.push_back(32'd7); exp_q.push_back(32'd8);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h440A) begin n_fail++; $display("FAIL ovf_full_status: got %h expected %h", d, 32'h440A); end
        bus_write(A_PUSH, 32'd100);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h442A) begin n_fail++; $display("FAIL ovf_err_status: got %h expected %h", d, 32'h442A); end
        bus_write(A_STATUS, 32'h2);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h440A) begin n_fail++; $display("FAIL ovf_clear_status: got %h expected %h", d, 32'h440A); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d, e;
        bit seen, ok;
        int s0;
        s0 = core_starts;
        repeat (20) @(posedge clk);
        n_cmp++; if (core_starts !== s0) begin n_fail++; $display("FAIL bp_no_start: got %0d starts expected 0", core_starts - s0); end
        bus_write(A_STATUS, 32'h1);
        void'(exp_q.pop_front());
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (bus.core_start === 1'b1) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL bp_restart: got no core_start expected one within 2 cycles"); end
        n_cmp++; if (bus.core_operand !== 32'd25) begin n_fail++; $display("FAIL bp_operand: got %h expected %h", bus.core_operand, 32'd25); end
        while (exp_q.size() > 0) begin
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                bus_read(A_STATUS, d);
                if (d[2] == 1'b0) begin ok = 1'b1; break; end
            end
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_drain_timeout: got empty expected result %h", exp_q[0]); break; end
            e = exp_q.pop_front();
            bus_read(A_RESULT, d);
            n_cmp++; if (d !== e) begin n_fail++; $display("FAIL bp_drain_order: got %h expected %h", d, e); end
            bus_write(A_STATUS, 32'h1);
        end
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h5) begin n_fail++; $display("FAIL bp_final_status: got %h expected %h", d, 32'h5); end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        bit seen;
        int s0;
        core_latency = 17;
        s0 = core_starts;
        bus_write(A_PUSH, 32'h100); bus_write(A_PUSH, 32'h200); bus_write(A_PUSH, 32'h300);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h214) begin n_fail++; $display("FAIL flush_pre_status: got %h expected %h", d, 32'h214); end
        bus_write(A_STATUS, 32'h4);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h15) begin n_fail++; $display("FAIL flush_wait_status: got %h expected %h", d, 32'h15); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.core_done === 1'b1) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL flush_done_timeout: got no core_done expected one"); end
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h5) begin n_fail++; $display("FAIL flush_post_status: got %h expected %h", d, 32'h5); end
        bus_read(A_RESULT, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL flush_result: got %h expected 0", d); end
        repeat (5) @(posedge clk);
        n_cmp++; if (core_starts - s0 !== 1) begin n_fail++; $display("FAIL flush_starts: got %0d expected 1", core_starts - s0); end
    endtask

    task automatic test_reset_mid_job();
        logic [31:0] d;
        bit ok;
        int s0;
        core_latency = 12;
        bus_write(A_PUSH, 32'h400);
        repeat (4) @(posedge clk);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h5) begin n_fail++; $display("FAIL rstmid_status: got %h expected %h", d, 32'h5); end
        n_cmp++; if (bus.core_operand !== 32'd0) begin n_fail++; $display("FAIL rstmid_operand: got %h expected 0", bus.core_operand); end
        s0 = core_starts;
        repeat (20) @(posedge clk);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h5) begin n_fail++; $display("FAIL rstmid_late_done: got %h expected %h", d, 32'h5); end
        n_cmp++; if (core_starts !== s0) begin n_fail++; $display("FAIL rstmid_starts: got %0d expected 0", core_starts - s0); end
        core_latency = 3;
        bus_write(A_IRQEN, 32'h1);
        bus_read(A_IRQEN, d);
`ifdef SQRT_SCHED_IRQ_EN
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL irqen_read: got %h expected 1", d); end
`else
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL irqen_read: got %h expected 0", d); end
`endif
        n_cmp++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b expected 0", bus.irq); end
        bus_write(A_PUSH, 32'd9);
        wait_results(1, 40, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL irq_timeout: got no result expected 1 result"); end
`ifdef SQRT_SCHED_IRQ_EN
        n_cmp++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b expected 1", bus.irq); end
`else
        n_cmp++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_set: got %b expected 0", bus.irq); end
`endif
        bus_read(A_RESULT, d);
        n_cmp++; if (d !== 32'd3) begin n_fail++; $display("FAIL irq_result: got %h expected 3", d); end
        bus_write(A_STATUS, 32'h1);
        #1;
        n_cmp++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b expected 0", bus.irq); end
    endtask

    task automatic test_random();
        logic [31:0] d, op, e, st;
        bit ok;
        int k;
        for (int r = 0; r < 8; r++) begin
            k = int'($urandom_range(1, 4));
            core_latency = int'($urandom_range(1, 10));
            for (int j = 0; j < k; j++) begin
                op = $urandom;
                exp_q.push_back(isqrt_ref(op) & 32'hFFFF);
                bus_write(A_PUSH, op);
            end
            wait_results(k, 300, ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand_timeout: got incomplete expected %0d results", k); end
            st = 32'h1 | ((k == 4) ? 32'h8 : 32'h0) | (32'(k) << 12);
            bus_read(A_STATUS, d);
            n_cmp++; if (d !== st) begin n_fail++; $display("FAIL rand_status: got %h expected %h", d, st); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                bus_read(A_RESULT, d);
                n_cmp++; if (d !== e) begin n_fail++; $display("FAIL rand_result: got %h expected %h", d, e); end
                bus_write(A_STATUS, 32'h1);
            end
        end
    endtask

    initial begin
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
        test_reset();
        test_single_job();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_flush();
        test_reset_mid_job();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
